// File: rtl/dcache_miss_ctrl.sv
// Miss sequencer between the LSU and the 2-way write-back dcache:
// lookup, dirty-victim writeback, 4-beat refill, line install and replay.
module dcache_miss_ctrl #(
    parameter int INIT_CYCLES = 512,
    parameter int BEATS       = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [3:0]   req_be,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic [31:0]  dc_addr,
    output logic         dc_r,
    output logic [15:0]  dc_wd,
    output logic [127:0] dc_din,
    input  logic [127:0] dc_dout,
    input  logic         dc_hit,
    input  logic         dc_dirty,
    input  logic [18:0]  dc_tout,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    output logic         mem_wvalid,
    output logic [31:0]  mem_wdata,
    input  logic         mem_wready,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata
);

    localparam int CW = $clog2(INIT_CYCLES);
    localparam int BW = $clog2(BEATS);

    localparam logic [3:0] S_INIT    = 4'd0;
    localparam logic [3:0] S_IDLE    = 4'd1;
    localparam logic [3:0] S_LOOK1   = 4'd2;
    localparam logic [3:0] S_LOOK2   = 4'd3;
    localparam logic [3:0] S_WB_REQ  = 4'd4;
    localparam logic [3:0] S_WB_DATA = 4'd5;
    localparam logic [3:0] S_RF_REQ  = 4'd6;
    localparam logic [3:0] S_RF_DATA = 4'd7;
    localparam logic [3:0] S_FILL    = 4'd8;
    localparam logic [3:0] S_REPLAY  = 4'd9;

    logic [3:0]    state;
    logic [CW-1:0] init_cnt;
    logic [BW-1:0] beat;
    logic          q_we;
    logic [31:0]   q_addr;
    logic [3:0]    q_be;
    logic [31:0]   q_wdata;
    logic [127:0]  victim;
    logic [18:0]   vtag;
    logic [127:0]  line_buf;
    logic          replay_q;
    logic          rsp_v;
    logic [31:0]   rsp_d;

    logic          issue;
    logic          iss_we;
    logic [31:0]   iss_addr;
    logic [3:0]    iss_be;
    logic [31:0]   iss_wdata;

    // The same issue path serves fresh requests and the post-fill replay.
    always_comb begin
        issue     = 1'b0;
        iss_we    = q_we;
        iss_addr  = q_addr;
        iss_be    = q_be;
        iss_wdata = q_wdata;
        if (state == S_IDLE) begin
            issue     = req_valid;
            iss_we    = req_we;
            iss_addr  = req_addr;
            iss_be    = req_be;
            iss_wdata = req_wdata;
        end else if (state == S_REPLAY) begin
            issue = 1'b1;
        end
    end

    always_comb begin
        dc_addr = '0;
        dc_r    = 1'b0;
        dc_wd   = '0;
        dc_din  = '0;
        if (issue) begin
            dc_addr = iss_addr;
            dc_r    = !iss_we;
            if (iss_we) begin
                dc_wd  = {12'b0, iss_be} << {iss_addr[3:2], 2'b00};
                dc_din = {4{iss_wdata}};
            end
        end else if (state == S_FILL) begin
            dc_addr = q_addr;
            dc_wd   = 16'hFFFF;
            dc_din  = line_buf;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (state == S_WB_REQ)
            mem_addr = {vtag, q_addr[12:4], 4'b0};
        else if (state == S_RF_REQ)
            mem_addr = {q_addr[31:4], 4'b0};
    end

    assign req_ready  = (state == S_IDLE);
    assign mem_req    = (state == S_WB_REQ) || (state == S_RF_REQ);
    assign mem_we     = (state == S_WB_REQ);
    assign mem_wvalid = (state == S_WB_DATA);
    assign mem_wdata  = mem_wvalid ? victim[{beat, 5'd0} +: 32] : 32'b0;
    assign resp_valid = rsp_v;
    assign resp_rdata = rsp_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
            beat     <= '0;
            q_we     <= 1'b0;
            q_addr   <= '0;
            q_be     <= '0;
            q_wdata  <= '0;
            victim   <= '0;
            vtag     <= '0;
            line_buf <= '0;
            replay_q <= 1'b0;
            rsp_v    <= 1'b0;
            rsp_d    <= '0;
        end else begin
            rsp_v <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (init_cnt == CW'(INIT_CYCLES - 1))
                        state <= S_IDLE;
                    else
                        init_cnt <= init_cnt + 1'b1;
                end
                S_IDLE: begin
                    if (req_valid) begin
                        q_we     <= req_we;
                        q_addr   <= req_addr;
                        q_be     <= req_be;
                        q_wdata  <= req_wdata;
                        replay_q <= 1'b0;
                        state    <= S_LOOK1;
                    end
                end
                S_LOOK1: state <= S_LOOK2;
                S_LOOK2: begin
                    if (dc_hit) begin
                        rsp_v <= 1'b1;
                        rsp_d <= q_we ? 32'b0
                                      : dc_dout[{q_addr[3:2], 5'd0} +: 32];
                        state <= S_IDLE;
                    end else begin
                        assert (!replay_q)
                        else $error("replayed access missed in dcache");
                        victim <= dc_dout;
                        vtag   <= dc_tout;
                        state  <= dc_dirty ? S_WB_REQ : S_RF_REQ;
                    end
                end
                S_WB_REQ: begin
                    beat <= '0;
                    if (mem_gnt)
                        state <= S_WB_DATA;
                end
                S_WB_DATA: begin
                    if (mem_wready) begin
                        beat <= beat + 1'b1;
                        if (beat == BW'(BEATS - 1)) begin
                            beat  <= '0;
                            state <= S_RF_REQ;
                        end
                    end
                end
                S_RF_REQ: begin
                    beat <= '0;
                    if (mem_gnt)
                        state <= S_RF_DATA;
                end
                S_RF_DATA: begin
                    if (mem_rvalid) begin
                        line_buf[{beat, 5'd0} +: 32] <= mem_rdata;
                        beat <= beat + 1'b1;
                        if (beat == BW'(BEATS - 1)) begin
                            beat  <= '0;
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: state <= S_REPLAY;
                S_REPLAY: begin
                    replay_q <= 1'b1;
                    state    <= S_LOOK1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl; the bench itself plays the dcache
// and the memory, driving their responses cycle by cycle.
module tb_dcache_miss_ctrl;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [3:0]   req_be;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic [31:0]  dc_addr;
    logic         dc_r;
    logic [15:0]  dc_wd;
    logic [127:0] dc_din;
    logic [127:0] dc_dout;
    logic         dc_hit;
    logic         dc_dirty;
    logic [18:0]  dc_tout;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_wvalid;
    logic [31:0]  mem_wdata;
    logic         mem_wready;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int nerr = 0;
    int nchk = 0;
    int nresp = 0;
    int n;

    dcache_miss_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .dc_addr(dc_addr), .dc_r(dc_r), .dc_wd(dc_wd),
        .dc_din(dc_din), .dc_dout(dc_dout), .dc_hit(dc_hit),
        .dc_dirty(dc_dirty), .dc_tout(dc_tout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_wvalid(mem_wvalid),
        .mem_wdata(mem_wdata), .mem_wready(mem_wready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (resp_valid) nresp <= nresp + 1;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h0000_1004;
        req_be = 4'h0;
        req_wdata = 32'h0;
        dc_dout = '0;
        dc_hit = 1'b0;
        dc_dirty = 1'b0;
        dc_tout = '0;
        mem_gnt = 1'b0;
        mem_wready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;

        nx();
        nx();
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_dc_r", dc_r, 0);
        check("rst_wvalid", mem_wvalid, 0);

        // Init window: first accept in cycle 513 after release.
        nx();
        reset = 1'b0;
        n = 1;
        #1;
        while (!req_ready && n < 600) begin
            nx();
            #1;
            n++;
        end
        check("init_len", n, 513);
        check("cold_issue_r", dc_r, 1);
        check("cold_issue_addr", dc_addr, 32'h0000_1004);
        check("cold_issue_wd", dc_wd, 0);
        dc_hit = 1'b0;
        dc_dirty = 1'b0;
        dc_tout = 19'h7;
        dc_dout = {4{32'hDEAD_0000}};

        nx();
        req_valid = 1'b0;
        #1;
        check("look1_r", dc_r, 0);
        check("look1_ready", req_ready, 0);
        nx();
        nx();
        #1;
        check("rf_req", mem_req, 1);
        check("rf_we", mem_we, 0);
        check("rf_addr", mem_addr, 32'h0000_1000);
        check("rf_no_wb", mem_wvalid, 0);
        mem_gnt = 1'b1;
        nx();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h11;
        #1;
        check("rf_data_req", mem_req, 0);
        nx();
        mem_rdata = 32'h22;
        nx();
        mem_rdata = 32'h33;
        nx();
        mem_rdata = 32'h44;
        nx();
        mem_rvalid = 1'b0;
        #1;
        check("fill_wd", dc_wd, 16'hFFFF);
        check("fill_addr", dc_addr, 32'h0000_1004);
        check("fill_din", dc_din, {32'h44, 32'h33, 32'h22, 32'h11});
        dc_hit = 1'b1;
        dc_dout = {32'h44, 32'h33, 32'h22, 32'h11};
        nx();
        #1;
        check("replay_r", dc_r, 1);
        check("replay_addr", dc_addr, 32'h0000_1004);
        nx();
        nx();
        nx();
        #1;
        check("cold_resp", resp_valid, 1);
        check("cold_rdata", resp_rdata, 32'h22);
        nx();
        #1;
        check("resp_pulse", resp_valid, 0);
        check("resp_count1", nresp, 1);

        // Store hit: 3-cycle latency, no memory traffic.
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h0000_1008;
        req_be = 4'b0011;
        req_wdata = 32'hAABB_CCDD;
        #1;
        check("st_wd", dc_wd, 16'h0300);
        check("st_din", dc_din, {4{32'hAABB_CCDD}});
        check("st_r", dc_r, 0);
        nx();
        req_valid = 1'b0;
        nx();
        #1;
        check("st_no_mem", mem_req, 0);
        nx();
        #1;
        check("st_resp", resp_valid, 1);
        check("st_rdata", resp_rdata, 0);

        // Dirty victim: delayed grant, write stalls, refill with gaps.
        nx();
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h0000_5000;
        dc_hit = 1'b0;
        dc_dirty = 1'b1;
        dc_tout = 19'h0;
        dc_dout = {32'h44, 32'h3344_CCDD, 32'h22, 32'h11};
        nx();
        req_valid = 1'b0;
        nx();
        nx();
        #1;
        check("wb_req", mem_req, 1);
        check("wb_we", mem_we, 1);
        check("wb_addr", mem_addr, 32'h0000_1000);
        for (int i = 0; i < 5; i++) begin
            nx();
            #1;
            check("wb_hold", {mem_req, mem_we, mem_addr},
                  {1'b1, 1'b1, 32'h0000_1000});
        end
        mem_gnt = 1'b1;
        nx();
        mem_gnt = 1'b0;
        mem_wready = 1'b1;
        #1;
        check("wb_valid", mem_wvalid, 1);
        check("wb_beat0", mem_wdata, 32'h11);
        nx();
        mem_wready = 1'b0;
        #1;
        check("wb_beat1", mem_wdata, 32'h22);
        nx();
        #1;
        check("wb_stall", {mem_wvalid, mem_wdata}, {1'b1, 32'h22});
        nx();
        mem_wready = 1'b1;
        #1;
        check("wb_stall2", {mem_wvalid, mem_wdata}, {1'b1, 32'h22});
        nx();
        #1;
        check("wb_beat2", mem_wdata, 32'h3344_CCDD);
        nx();
        #1;
        check("wb_beat3", mem_wdata, 32'h44);
        nx();
        mem_wready = 1'b0;
        #1;
        check("wb_done", mem_wvalid, 0);
        check("rf2_req", {mem_req, mem_we, mem_addr},
              {1'b1, 1'b0, 32'h0000_5000});
        mem_gnt = 1'b1;
        nx();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hA0A0_A0A0;
        nx();
        mem_rvalid = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        nx();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hA1A1_A1A1;
        nx();
        mem_rvalid = 1'b0;
        nx();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hA2A2_A2A2;
        nx();
        mem_rdata = 32'hA3A3_A3A3;
        nx();
        mem_rvalid = 1'b0;
        #1;
        check("fill2_din", dc_din, {32'hA3A3_A3A3, 32'hA2A2_A2A2,
                                    32'hA1A1_A1A1, 32'hA0A0_A0A0});
        dc_hit = 1'b1;
        dc_dirty = 1'b0;
        dc_dout = {32'hA3A3_A3A3, 32'hA2A2_A2A2,
                   32'hA1A1_A1A1, 32'hA0A0_A0A0};
        nx();
        #1;
        check("replay2_addr", {dc_r, dc_addr}, {1'b1, 32'h0000_5000});
        nx();
        nx();
        nx();
        #1;
        check("wb_resp", resp_valid, 1);
        check("wb_rdata", resp_rdata, 32'hA0A0_A0A0);

        // Reset in the middle of a refill discards the request.
        nx();
        req_valid = 1'b1;
        req_addr = 32'h0000_3000;
        dc_hit = 1'b0;
        dc_dirty = 1'b0;
        nx();
        req_valid = 1'b0;
        nx();
        nx();
        #1;
        check("rf3_addr", mem_addr, 32'h0000_3000);
        mem_gnt = 1'b1;
        nx();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hB0;
        nx();
        mem_rdata = 32'hB1;
        nx();
        mem_rdata = 32'hB2;
        reset = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_resp", resp_valid, 0);
        check("abort_ready", req_ready, 0);
        check("abort_wd", dc_wd, 0);
        mem_rvalid = 1'b0;
        nx();
        nx();
        req_valid = 1'b1;
        req_addr = 32'h0000_2004;
        dc_hit = 1'b1;
        reset = 1'b0;
        n = 1;
        #1;
        while (!req_ready && n < 600) begin
            nx();
            #1;
            n++;
        end
        check("reinit_len", n, 513);
        check("abort_no_resp", nresp, 3);
        nx();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) nx();
        check("post_init_resp", nresp, 4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
